// File: rtl/regfile_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_sb : parametrised 2R/1W register file with clear sweep and busy scoreboard
// Revision   : 1.0
// ----------------------------------------------------------------------------
module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            we3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            mark_en,
  input  logic [AW-1:0]   mark_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]    regs_q [NREGS];

  logic w_run;
  logic w_clr;
  logic w_wr;

  assign w_run = (state_q == S_RUN);
  assign w_clr = (state_q == S_CLEAR);
  assign w_wr  = w_run && we3 && (A3 != '0);
  assign ready = w_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      S_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        // Set is applied after clear so a freshly issued producer wins.
        if (we3)     busy_d[A3]        = 1'b0;
        if (mark_en) busy_d[mark_addr] = 1'b1;
        busy_d[0] = 1'b0;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr)     regs_q[idx_q] <= '0;
      else if (w_wr) regs_q[A3]    <= WD3;
    end
  end

  logic [AW-1:0] w_ra [2];
  assign w_ra[0] = A1;
  assign w_ra[1] = A2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic            hit;
    logic [XLEN-1:0] rd;
    logic            bsy;

    assign hit = w_run && we3 && (A3 == w_ra[p]);

    always_comb begin
      rd  = '0;
      bsy = 1'b0;
      if (w_run && (w_ra[p] != '0)) begin
        rd  = ((BYPASS != 0) && hit) ? WD3 : regs_q[w_ra[p]];
        bsy = busy_q[w_ra[p]] & ~hit;
      end
    end
  end

  assign RD1   = g_rd[0].rd;
  assign RD2   = g_rd[1].rd;
  assign busy1 = g_rd[0].bsy;
  assign busy2 = g_rd[1].bsy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// Testbench for regfile_sb: default instance with and without bypass, plus a 64x16 instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we3, mark_en;
  logic [4:0]  a1, a2, a3, ma;
  logic [31:0] wd3;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        b1_b, b2_b, rdy_b, b1_n, b2_n, rdy_n;

  logic        p_rst, p_we3, p_mk;
  logic [3:0]  p_a1, p_a2, p_a3, p_ma;
  logic [63:0] p_wd, p_rd1, p_rd2;
  logic        p_b1, p_b2, p_rdy;

  regfile_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
    .we3(we3), .A3(a3), .WD3(wd3), .mark_en(mark_en), .mark_addr(ma),
    .busy1(b1_b), .busy2(b2_b), .ready(rdy_b));

  regfile_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
    .we3(we3), .A3(a3), .WD3(wd3), .mark_en(mark_en), .mark_addr(ma),
    .busy1(b1_n), .busy2(b2_n), .ready(rdy_n));

  regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(1)) u_wide (
    .clk(clk), .rst(p_rst), .A1(p_a1), .A2(p_a2), .RD1(p_rd1), .RD2(p_rd2),
    .we3(p_we3), .A3(p_a3), .WD3(p_wd), .mark_en(p_mk), .mark_addr(p_ma),
    .busy1(p_b1), .busy2(p_b2), .ready(p_rdy));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        mk;
    logic [4:0]  ma;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd1n;
    logic [31:0] rd2;
    logic [31:0] rd2n;
    logic        b1;
    logic        b2;
  } vec_t;

  vec_t vecs [17];

  // Releases nothing itself; counts edges until ready, optionally injecting a write/mark mid-sweep.
  task automatic sweep_main(input bit pulse, output int n);
    n = 0;
    while (!rdy_b && n < 100) begin
      if (pulse && n == 10) begin
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000DEAD; mark_en = 1'b1; ma = 5'd6;
      end else begin
        we3 = 1'b0; mark_en = 1'b0;
      end
      if (n == 20) begin
        chk("clear rd1", 64'(rd1_b), 64'h0);
        chk("clear busy2", 64'(b2_b), 64'h0);
      end
      @(posedge clk); #1;
      n++;
    end
    we3 = 1'b0; mark_en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; we3 = 1'b0; mark_en = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; ma = '0; wd3 = '0;
    p_rst = 1'b1; p_we3 = 1'b0; p_mk = 1'b0;
    p_a1 = '0; p_a2 = '0; p_a3 = '0; p_ma = '0; p_wd = '0;

    //        we    a3     wd            mk    ma     a1     a2     rd1           rd1n          rd2           rd2n          b1    b2
    vecs[0]  = '{1'b1, 5'd5, 32'h00000005, 1'b0, 5'd0, 5'd5, 5'd0, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd5, 5'd0, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd5, 5'd0, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd5, 32'h12345678, 32'h00000000, 32'h00000005, 32'h00000005, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd6, 5'd6, 5'd7, 32'h00000000, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd6, 5'd6, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 5'd6, 32'hAAAA0006, 1'b0, 5'd0, 5'd6, 5'd0, 32'hAAAA0006, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd6, 5'd6, 32'hAAAA0006, 32'hAAAA0006, 32'hAAAA0006, 32'hAAAA0006, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd6, 32'hBBBB0006, 1'b1, 5'd6, 5'd6, 5'd5, 32'hBBBB0006, 32'hAAAA0006, 32'h00000005, 32'h00000005, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd6, 5'd6, 32'hBBBB0006, 32'hBBBB0006, 32'hBBBB0006, 32'hBBBB0006, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'h00000000, 1'b1, 5'd0, 5'd6, 5'd0, 32'hBBBB0006, 32'hBBBB0006, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd0, 5'd6, 32'h00000000, 32'h00000000, 32'hBBBB0006, 32'hBBBB0006, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4, 5'd3, 5'd4, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd3, 5'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 5'd6, 32'hC0000006, 1'b0, 5'd0, 5'd6, 5'd6, 32'hC0000006, 32'hBBBB0006, 32'hC0000006, 32'hBBBB0006, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 5'd6, 5'd4, 32'hC0000006, 32'hC0000006, 32'h00000000, 32'h00000000, 1'b0, 1'b1};

    // Initial reset sweep with a dropped mid-sweep write/mark
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(rdy_b), 64'h0);
    chk("reset busy1", 64'(b1_b), 64'h0);
    rst = 1'b0; a1 = 5'd5; a2 = 5'd6;
    sweep_main(1'b1, n);
    chk("sweep edges", 64'(n), 64'd32);
    chk("sweep ready nobyp", 64'(rdy_n), 64'h1);
    chk("sweep dropped write", 64'(rd1_b), 64'h0);
    chk("sweep dropped mark", 64'(b2_b), 64'h0);

    for (int i = 0; i < 17; i++) begin
      we3 = vecs[i].we; a3 = vecs[i].a3; wd3 = vecs[i].wd;
      mark_en = vecs[i].mk; ma = vecs[i].ma; a1 = vecs[i].a1; a2 = vecs[i].a2;
      @(negedge clk);
      chk($sformatf("v%0d rd1 byp", i), 64'(rd1_b), 64'(vecs[i].rd1));
      chk($sformatf("v%0d rd1 nob", i), 64'(rd1_n), 64'(vecs[i].rd1n));
      chk($sformatf("v%0d rd2 byp", i), 64'(rd2_b), 64'(vecs[i].rd2));
      chk($sformatf("v%0d rd2 nob", i), 64'(rd2_n), 64'(vecs[i].rd2n));
      chk($sformatf("v%0d busy1", i), 64'(b1_b), 64'(vecs[i].b1));
      chk($sformatf("v%0d busy2", i), 64'(b2_b), 64'(vecs[i].b2));
      chk($sformatf("v%0d busy1 nob", i), 64'(b1_n), 64'(vecs[i].b1));
      chk($sformatf("v%0d ready", i), 64'(rdy_b), 64'h1);
      @(posedge clk); #1;
    end
    we3 = 1'b0; mark_en = 1'b0;

    // Reset mid-run: reg3 = A5A5A5A5, reg4 busy
    a1 = 5'd3; a2 = 5'd4;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready", 64'(rdy_b), 64'h0);
    chk("midrst busy2", 64'(b2_b), 64'h0);
    chk("midrst rd1", 64'(rd1_b), 64'h0);
    rst = 1'b0; a1 = 5'd5;
    sweep_main(1'b1, n);
    chk("midrst sweep edges", 64'(n), 64'd32);
    a1 = 5'd3; a2 = 5'd4;
    @(negedge clk);
    chk("midrst reg3 cleared", 64'(rd1_b), 64'h0);
    chk("midrst busy4 clear", 64'(b2_b), 64'h0);
    a1 = 5'd5; a2 = 5'd6;
    @(negedge clk);
    chk("midrst reg5 cleared", 64'(rd1_b), 64'h0);
    chk("midrst reg6 cleared", 64'(rd2_n), 64'h0);
    @(posedge clk); #1;

    // 64-bit, 16-entry instance
    p_rst = 1'b0;
    n = 0;
    while (!p_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wide sweep edges", 64'(n), 64'd16);
    p_a1 = 4'd15; p_a2 = 4'd5;
    @(negedge clk);
    chk("wide clear rd1", p_rd1, 64'h0);
    chk("wide clear rd2", p_rd2, 64'h0);
    @(posedge clk); #1;
    p_we3 = 1'b1; p_a3 = 4'd5; p_wd = 64'hDEADBEEF_CAFEF00D; p_a1 = 4'd5; p_a2 = 4'd0;
    @(negedge clk);
    chk("wide bypass", p_rd1, 64'hDEADBEEF_CAFEF00D);
    @(posedge clk); #1;
    p_a3 = 4'd0; p_wd = '1;
    @(posedge clk); #1;
    p_a3 = 4'd15; p_wd = 64'h80000000_00000001;
    @(posedge clk); #1;
    p_we3 = 1'b0; p_a1 = 4'd5; p_a2 = 4'd15;
    @(negedge clk);
    chk("wide rd1", p_rd1, 64'hDEADBEEF_CAFEF00D);
    chk("wide rd2 top", p_rd2, 64'h80000000_00000001);
    chk("wide busy1", 64'(p_b1), 64'h0);
    p_a2 = 4'd0;
    @(negedge clk);
    chk("wide rd2 x0", p_rd2, 64'h0);
    chk("wide busy2", 64'(p_b2), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
